// File: rtl/seg7_pkg.sv
// Shared segment patterns, FSM state type and {dp,s} decode for the 7-segment readback path.
package seg7_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned PAT_W = SEG_W + 1;
    localparam int unsigned VAL_W = 4;

    localparam logic [SEG_W-1:0] SEG_P0    = 7'b1110111;
    localparam logic [SEG_W-1:0] SEG_P1    = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_P2    = 7'b1011101;
    localparam logic [SEG_W-1:0] SEG_P4    = 7'b0111010;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_BLANK  = 2'd2,
        ST_ERR    = 2'd3
    } rx_state_e;

    typedef enum logic [1:0] {
        CLS_LEGAL   = 2'd0,
        CLS_BLANK   = 2'd1,
        CLS_ILLEGAL = 2'd2
    } seg_cls_e;

    typedef struct packed {
        seg_cls_e           cls;
        logic [VAL_W-1:0]   value;
    } seg_dec_t;

    // Map a display pattern back to its signed value; dp carries the sign.
    function automatic seg_dec_t seg_decode(input logic dp, input logic [SEG_W-1:0] s);
        seg_dec_t d;
        d.cls   = CLS_ILLEGAL;
        d.value = '0;
        if (!dp) begin
            case (s)
                SEG_P0:    begin d.cls = CLS_LEGAL; d.value = 4'b0000; end
                SEG_P1:    begin d.cls = CLS_LEGAL; d.value = 4'b0001; end
                SEG_P2:    begin d.cls = CLS_LEGAL; d.value = 4'b0010; end
                SEG_P4:    begin d.cls = CLS_LEGAL; d.value = 4'b0100; end
                SEG_BLANK: d.cls = CLS_BLANK;
                default:   d.cls = CLS_ILLEGAL;
            endcase
        end else begin
            case (s)
                SEG_P1:  begin d.cls = CLS_LEGAL; d.value = 4'b1111; end
                SEG_P2:  begin d.cls = CLS_LEGAL; d.value = 4'b1110; end
                default: d.cls = CLS_ILLEGAL;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/seg7_sync.sv
// N-stage synchroniser for a bus of asynchronous inputs; async active-low reset to zero.
module seg7_sync #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stg [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stg[i] <= '0;
            end
        end else begin
            stg[0] <= d;
            for (int i = 1; i < int'(STAGES); i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign q = stg[STAGES-1];

endmodule

// File: rtl/seg7_rx_decoder.sv
// Samples, debounces and decodes a 7-segment display back to a signed 4-bit value.
// Optional SEG7_RX_ERRCNT_EN adds a saturating count of illegal-pattern acceptances (err_cnt).
module seg7_rx_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEG_W-1:0] s,
    input  logic             dp,
    output logic [VAL_W-1:0] value,
    output logic             value_vld,
    output logic             locked,
    output logic             blank,
    output logic             err
`ifdef SEG7_RX_ERRCNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(STABLE_CYCLES - 1);

    logic [PAT_W-1:0] pat_s;
    logic [PAT_W-1:0] pat_q;
    logic             match;
    logic [CNT_W-1:0] cnt;
    seg_dec_t         dec;

    rx_state_e        state;
    rx_state_e        state_d;
    logic [VAL_W-1:0] value_d;
    logic             vld_d;

    seg7_sync #(
        .WIDTH  (PAT_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({dp, s}),
        .q     (pat_s)
    );

    assign match = (pat_s == pat_q);
    assign dec   = seg_decode(pat_s[PAT_W-1], pat_s[SEG_W-1:0]);

    // Previous synchronised sample plus saturating run-length of identical samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q <= '0;
            cnt   <= '0;
        end else begin
            pat_q <= pat_s;
            if (!match) begin
                cnt <= '0;
            end else if (cnt < CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_WAIT;
        end else begin
            state <= state_d;
        end
    end

    // Classify a settled pattern from WAIT; any movement on the pins drops back to WAIT.
    always_comb begin
        state_d = state;
        value_d = value;
        vld_d   = 1'b0;
        case (state)
            ST_WAIT: begin
                if (match && (cnt == CNT_ACC)) begin
                    case (dec.cls)
                        CLS_LEGAL: begin
                            state_d = ST_LOCKED;
                            value_d = dec.value;
                            vld_d   = 1'b1;
                        end
                        CLS_BLANK: state_d = ST_BLANK;
                        default:   state_d = ST_ERR;
                    endcase
                end
            end
            ST_LOCKED, ST_BLANK, ST_ERR: begin
                if (!match) begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    // Flags are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value     <= '0;
            value_vld <= 1'b0;
            locked    <= 1'b0;
            blank     <= 1'b0;
            err       <= 1'b0;
        end else begin
            value     <= value_d;
            value_vld <= vld_d;
            locked    <= (state_d == ST_LOCKED);
            blank     <= (state_d == ST_BLANK);
            err       <= (state_d == ST_ERR);
        end
    end

`ifdef SEG7_RX_ERRCNT_EN
    // Counts entries into ERR, not cycles spent there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if ((state == ST_WAIT) && (state_d == ST_ERR) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seg7_rx_decoder.sv
// Scoreboarded random/directed bench for seg7_rx_decoder (honours SEG7_RX_ERRCNT_EN when defined).
module tb_seg7_rx_decoder;

    localparam int SYNC = 2;
    localparam int STAB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] s = 7'b0010010;
    logic       dp = 1'b1;
    logic [3:0] value;
    logic       value_vld;
    logic       locked;
    logic       blank;
    logic       err;
`ifdef SEG7_RX_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    always #5 clk = ~clk;

    seg7_rx_decoder #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STAB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s         (s),
        .dp        (dp),
        .value     (value),
        .value_vld (value_vld),
        .locked    (locked),
        .blank     (blank),
        .err       (err)
`ifdef SEG7_RX_ERRCNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    // Expected acceptance window of one held pattern: cls 1=locked 2=blank 3=err.
    typedef struct {
        int         acc;
        int         ext;
        int         cls;
        logic [3:0] val;
    } rec_t;

    typedef struct {
        int         at;
        logic [3:0] val;
    } pulse_t;

    rec_t       flag_q[$];
    pulse_t     pulse_q[$];
    int         total = 0;
    int         bad = 0;
    int         edge_n;
    bit         mon_en = 1'b0;
    logic [3:0] m_val = 4'd0;
    int         m_errs = 0;
    logic [7:0] cur = 8'h00;

    logic [7:0] leg_pat [6] = '{8'b0_1110111, 8'b0_0010010, 8'b0_1011101,
                                8'b0_0111010, 8'b1_0010010, 8'b1_1011101};
    logic [3:0] leg_val [6] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd15, 4'd14};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", nm, act, exp, edge_n, $time);
        end
    endtask

    function automatic void classify(input logic [7:0] p, output int cls, output logic [3:0] v);
        cls = (p == 8'h00) ? 2 : 3;
        v   = 4'd0;
        for (int i = 0; i < 6; i++) begin
            if (p == leg_pat[i]) begin
                cls = 1;
                v   = leg_val[i];
            end
        end
    endfunction

    function automatic logic [7:0] pick(input logic [7:0] prev);
        logic [7:0] p;
        int r;
        do begin
            r = int'($urandom_range(0, 10));
            case (r)
                0, 1, 2, 3, 4, 5: p = leg_pat[r];
                6:       p = 8'h00;
                7:       p = 8'h7F;
                8:       p = 8'h80;
                9:       p = 8'b1_1110111;
                default: p = 8'($urandom);
            endcase
        end while (p == prev);
        return p;
    endfunction

    // Drive a pattern for h clock edges and record what the decoder must do with it.
    task automatic seg(input logic [7:0] p, input int h);
        int e0;
        int c;
        logic [3:0] v;
        e0 = edge_n + 1;
        {dp, s} = p;
        cur = p;
        classify(p, c, v);
        if (h >= STAB + 1) begin
            flag_q.push_back('{e0 + SYNC + STAB, e0 + h + SYNC, c, v});
            if (c == 1) pulse_q.push_back('{e0 + SYNC + STAB, v});
        end
        repeat (h) @(negedge clk);
    endtask

    // Monitor: compares flags/value every cycle and pops the pulse scoreboard on value_vld.
    always @(negedge clk) begin : mon
        int t;
        int ecls;
        pulse_t pp;
        if (mon_en && rst_n) begin
            t = edge_n;
            while (flag_q.size() > 0 && flag_q[0].ext <= t) void'(flag_q.pop_front());
            ecls = 0;
            if (flag_q.size() > 0 && flag_q[0].acc <= t) ecls = flag_q[0].cls;
            if (flag_q.size() > 0 && flag_q[0].acc == t) begin
                if (flag_q[0].cls == 1) m_val = flag_q[0].val;
                if (flag_q[0].cls == 3 && m_errs < 255) m_errs++;
            end
            chk("locked", int'(locked), int'(ecls == 1));
            chk("blank", int'(blank), int'(ecls == 2));
            chk("err", int'(err), int'(ecls == 3));
            chk("value", int'(value), int'(m_val));
`ifdef SEG7_RX_ERRCNT_EN
            chk("err_cnt", int'(err_cnt), m_errs);
`endif
            if (value_vld) begin
                if (pulse_q.size() == 0) begin
                    chk("spurious_vld", 1, 0);
                end else begin
                    pp = pulse_q.pop_front();
                    chk("vld_edge", t, pp.at);
                    chk("vld_value", int'(value), int'(pp.val));
                end
            end else if (pulse_q.size() > 0 && pulse_q[0].at < t) begin
                void'(pulse_q.pop_front());
                chk("missed_vld", 0, 1);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int h;
        logic [7:0] p;
        repeat (3) @(negedge clk);
        chk("rst_value", int'(value), 0);
        chk("rst_flags", int'({value_vld, locked, blank, err}), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Directed sequences: negative one, locked switch, glitch, illegal, blank.
        seg(8'b1_0010010, 10);
        seg(8'b0_1110111, 10);
        seg(8'b0_0111010, 10);
        seg(8'b0_1011101, 3);
        seg(8'b0_0010010, 10);
        seg(8'h7F, 10);
        seg(8'b0_1011101, 10);
        seg(8'b1_1110111, 10);
        seg(8'b0_1011101, 10);
        seg(8'h00, 10);

        for (int i = 0; i < 250; i++) begin
            p = pick(cur);
            h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 12));
            seg(p, h);
        end

        // Asynchronous reset while locked on +1.
        if (cur == 8'b0_0010010) seg(8'b0_0111010, 8);
        seg(8'b0_0010010, 10);
        chk("pre_rst_locked", int'(locked), 1);
        chk("pre_rst_value", int'(value), 1);
        mon_en = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        {dp, s} = 8'h00;
        #1;
        chk("async_rst_value", int'(value), 0);
        chk("async_rst_locked", int'(locked), 0);
`ifdef SEG7_RX_ERRCNT_EN
        chk("async_rst_err_cnt", int'(err_cnt), 0);
`endif
        repeat (3) @(negedge clk);
        flag_q.delete();
        pulse_q.delete();
        m_val  = 4'd0;
        m_errs = 0;
        rst_n  = 1'b1;

        // Pins already blank out of reset.
        n = 0;
        while (!blank && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("post_rst_blank", int'(blank), 1);
        chk("post_rst_value", int'(value), 0);
        chk("post_rst_locked", int'(locked), 0);
        flag_q.push_back('{0, edge_n + 1 + SYNC, 2, 4'd0});
        cur = 8'h00;
        mon_en = 1'b1;

`ifdef SEG7_RX_ERRCNT_EN
        for (int i = 0; i < 300; i++) begin
            seg((i % 2 == 0) ? 8'h7F : 8'h80, 5);
        end
        seg(8'b0_0010010, 10);
        chk("err_cnt_sat", int'(err_cnt), 255);
`else
        for (int i = 0; i < 30; i++) begin
            seg(pick(cur), int'($urandom_range(1, 12)));
        end
`endif
        seg(pick(cur), 12);
        mon_en = 1'b0;
        chk("pulse_drain", pulse_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_rx_decoder.md
Name: seg7_rx_decoder

Overview:
Receive-side counterpart of the signed-product 7-segment display driver. Samples the segment lines and decimal point of a driven display, synchronises and debounces them, and decodes the pattern back to a 4-bit signed value. Sits on the test/readback path so a second board or self-check logic can recover what a display is showing. Flags blank and illegal patterns.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on s/dp (min 2).
STABLE_CYCLES, 4, consecutive identical synchronised samples needed to accept a pattern (min 1).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
s  input  7  segment lines, asynchronous to clk, same bit order/encoding as the display driver.
dp  input  1  decimal point; 1 = negative sign.
value  output  4  signed decoded value, holds last accepted digit.
value_vld  output  1  one-cycle pulse on every acceptance of a legal digit.
locked  output  1  1 while a legal digit is currently accepted and unchanged.
blank  output  1  1 while an all-off pattern (s=0000000, dp=0) is accepted.
err  output  1  1 while an illegal pattern is accepted.
err_cnt  output  8  illegal-pattern entry count (present only with SEG7_RX_ERRCNT_EN).

Behaviour:
- Interface decided: one clock clk; reset rst_n is asynchronous and active-low.
- Reset (async, immediate): sync flops=0, value=0, value_vld=0, locked=0, blank=0, err=0, err_cnt=0, state=WAIT, stability counter=0.
- Sync: {dp,s} through SYNC_STAGES flops → pat_s. pat_q <= pat_s every cycle; match = (pat_s == pat_q).
- Counter cnt, width clog2(STABLE_CYCLES+1): !match → 0; match and cnt<STABLE_CYCLES → +1; saturates.
- Legal table, {dp,s} → value: 0_1110111→0000, 0_0010010→0001, 0_1011101→0010, 0_0111010→0100, 1_0010010→1111, 1_1011101→1110. Blank: 0_0000000. Anything else is illegal, including dp=1 with zero or four, and dp=1 with all segments off.
- FSM states: WAIT, LOCKED, BLANK, ERR.
- WAIT: when match && cnt==STABLE_CYCLES-1, classify pat_s:
  - legal → LOCKED; value loaded; value_vld=1 for exactly one cycle.
  - blank → BLANK.
  - illegal → ERR.
- LOCKED/BLANK/ERR: any !match → WAIT next edge. locked/blank/err deassert on entering WAIT; value holds.
- Flag decoding: locked=(state==LOCKED), blank=(state==BLANK), err=(state==ERR). All registered, mutually exclusive.
- Latency: pins change then hold → value_vld asserts exactly SYNC_STAGES+STABLE_CYCLES+1 rising edges later (7 with defaults).
- Exit latency: after pins change, locked falls SYNC_STAGES+1 edges later.
- Glitches: a pattern held for fewer than STABLE_CYCLES sampled cycles is never accepted and produces no pulse.
- Re-acceptance of the same digit after leaving LOCKED pulses value_vld again.
- Post-reset: pins at blank → blank asserts after the normal acceptance latency.

Optional Feature:
SEG7_RX_ERRCNT_EN:
- Defined: err_cnt port exists. Increments by 1 on each WAIT→ERR transition and saturates at 255. Reset to 0 by rst_n only.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package seg7_pkg holds:
  - segment pattern localparams SEG_P0, SEG_P1, SEG_P2, SEG_P4, SEG_BLANK.
  - the 2-bit FSM state enum.
  - a decode function {dp,s} → {class, value}, shared with the driver's checker.
- Sub-module seg7_sync: parameterised N-stage synchroniser with async active-low reset, instantiated 8 bits wide.

Test Plan:
1. Reset, then hold s=0010010, dp=1 → value_vld high for exactly 1 cycle on edge 7; value=1111; locked=1; blank=err=0.
2. Locked on s=1110111, dp=0 (value 0000), then switch to s=0111010, dp=0 → locked=0 on edge 3 after the change with value still 0000; value_vld on edge 7 with value=0100.
3. s=1011101 held 3 cycles, then s=0010010, dp=0 held → no pulse for 2; single pulse, value=0001.
4. s=1111111, dp=0, then s=1110111, dp=1 (with an intervening legal digit) → err=1 each time, locked=0, value unchanged; with macro, err_cnt=2.
5. s=0000000, dp=0 after a locked 2 → blank=1, locked=0, value stays 0010, no pulse.
6. rst_n driven low mid-LOCKED, between clock edges → value, locked and err_cnt go to 0 immediately, before the next clk edge. With macro: force 300 ERR entries → err_cnt=255.
